// File: rtl/pep9_mem_responder_if.sv
// ---------------------------------------------------------------------------
// pep9_mem_responder_if
//
// Purpose : Pep9 system-bus bundle between a bus initiator (CPU or bench)
//           and the memory responder. Clock and reset are not part of the
//           bundle; they stay plain ports on the modules.
//
// Signals :
//   MemReq       initiator -> responder  request valid, level, held until DoneMem
//   we           initiator -> responder  1 = write, 0 = read
//   address      initiator -> responder  byte address (ADDR_W bits)
//   DatatoWrite  initiator -> responder  write data byte
//   DatatoRead   responder -> initiator  read data byte, held until next read
//   DoneMem      responder -> initiator  one-cycle completion pulse
//   Busy         responder -> initiator  high from acceptance through DoneMem
//   MemErr       responder -> initiator  out-of-range flag, coincident with
//                                        DoneMem (only when MEM_BOUNDS_ERR_EN
//                                        is defined)
//
// Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface pep9_mem_responder_if #(
  parameter int ADDR_W = 16
) ();

  logic              MemReq;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [7:0]        DatatoWrite;
  logic [7:0]        DatatoRead;
  logic              DoneMem;
  logic              Busy;
`ifdef MEM_BOUNDS_ERR_EN
  logic              MemErr;
`endif

  modport master (
    output MemReq,
    output we,
    output address,
    output DatatoWrite,
    input  DatatoRead,
    input  DoneMem,
    input  Busy
`ifdef MEM_BOUNDS_ERR_EN
    , input MemErr
`endif
  );

  modport slave (
    input  MemReq,
    input  we,
    input  address,
    input  DatatoWrite,
    output DatatoRead,
    output DoneMem,
    output Busy
`ifdef MEM_BOUNDS_ERR_EN
    , output MemErr
`endif
  );

endinterface : pep9_mem_responder_if

// File: rtl/pep9_mem_responder.sv
// ---------------------------------------------------------------------------
// pep9_mem_responder
//
// Purpose : Target end of the Pep9 system bus. Accepts one byte read or
//           write request at a time, waits WAIT_CYCLES clocks, performs the
//           access on an internal byte RAM and signals completion with a
//           one-cycle DoneMem pulse.
//
// Ports   :
//   Sysclk  in   system clock, all logic on the rising edge
//   reset   in   synchronous active-high reset (RAM contents survive it)
//   bus     slave modport of pep9_mem_responder_if (MemReq, we, address,
//           DatatoWrite in; DatatoRead, DoneMem, Busy [, MemErr] out)
//
// Timing  : counting the cycle right after the accepting edge as cycle 1,
//           the FSM spends cycles 1..WAIT_CYCLES in WAIT, cycle
//           WAIT_CYCLES+1 in ACCESS and cycle WAIT_CYCLES+2 in DONE, where
//           DoneMem is high. Busy is high for all WAIT_CYCLES+2 of them.
//           At least one IDLE cycle separates consecutive transactions.
//
// Option  : `define MEM_BOUNDS_ERR_EN adds the MemErr output. Addresses
//           >= MEM_DEPTH then run the normal timing but perform no access
//           and raise MemErr alongside DoneMem. Without the macro such
//           addresses alias into the RAM (upper bits discarded).
// ---------------------------------------------------------------------------
module pep9_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                Sysclk,
  input  logic                reset,
  pep9_mem_responder_if.slave bus
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Terminal count of the wait counter; unused when WAIT_CYCLES is 0
  // because IDLE then jumps straight to ACCESS.
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // FSM and wait counter
  state_e           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;

  // Request fields captured on acceptance; the live bus is ignored while busy
  logic [IDX_W-1:0] addr_lat_q, addr_lat_d;
  logic             we_lat_q, we_lat_d;
  logic [7:0]       data_lat_q, data_lat_d;

  // Registered outputs
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       rdata_q, rdata_d;

  // RAM and its write strobe
  logic [7:0]       mem_q [MEM_DEPTH];
  logic             mem_we_s;

  // High when the latched request may touch the RAM
  logic             access_en_s;

`ifdef MEM_BOUNDS_ERR_EN
  logic             oob_lat_q, oob_lat_d;
  logic             mem_err_q, mem_err_d;

  // True when a bus address lies beyond the implemented RAM
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} >= (ADDR_W + 1)'(MEM_DEPTH));
  endfunction

  assign access_en_s = ~oob_lat_q;
`else
  assign access_en_s = 1'b1;

  // Upper address bits are deliberately discarded (aliasing); fold them into
  // a sink so the drop is visibly intentional.
  if (IDX_W < ADDR_W) begin : g_addr_hi
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^bus.address[ADDR_W-1:IDX_W];
  end
`endif

  // Next-state, request capture, access and next-output logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_lat_d = addr_lat_q;
    we_lat_d   = we_lat_q;
    data_lat_d = data_lat_q;
    rdata_d    = rdata_q;
    mem_we_s   = 1'b0;
`ifdef MEM_BOUNDS_ERR_EN
    oob_lat_d  = oob_lat_q;
`endif

    case (state_q)
      IDLE: begin
        wait_cnt_d = 4'd0;
        if (bus.MemReq) begin
          addr_lat_d = bus.address[IDX_W-1:0];
          we_lat_d   = bus.we;
          data_lat_d = bus.DatatoWrite;
`ifdef MEM_BOUNDS_ERR_EN
          oob_lat_d  = addr_out_of_range(bus.address);
`endif
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = 4'd0;
          state_d    = ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
          state_d    = WAIT;
        end
      end

      ACCESS: begin
        state_d = DONE;
        // Writes leave DatatoRead alone; reads refresh it
        if (access_en_s) begin
          if (we_lat_q) begin
            mem_we_s = 1'b1;
          end else begin
            rdata_d = mem_q[addr_lat_q];
          end
        end else begin
          rdata_d = rdata_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
`ifdef MEM_BOUNDS_ERR_EN
    mem_err_d = (state_d == DONE) && oob_lat_q;
`endif
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge Sysclk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      addr_lat_q <= '0;
      we_lat_q   <= 1'b0;
      data_lat_q <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= 8'h00;
`ifdef MEM_BOUNDS_ERR_EN
      oob_lat_q  <= 1'b0;
      mem_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_lat_q <= addr_lat_d;
      we_lat_q   <= we_lat_d;
      data_lat_q <= data_lat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
`ifdef MEM_BOUNDS_ERR_EN
      oob_lat_q  <= oob_lat_d;
      mem_err_q  <= mem_err_d;
`endif
    end
  end

  // RAM write port; no reset so contents survive, and a reset landing on
  // the ACCESS cycle drops the write like any other pending access
  always_ff @(posedge Sysclk) begin
    if (mem_we_s && !reset) begin
      mem_q[addr_lat_q] <= data_lat_q;
    end
  end

  assign bus.DatatoRead = rdata_q;
  assign bus.DoneMem    = done_q;
  assign bus.Busy       = busy_q;
`ifdef MEM_BOUNDS_ERR_EN
  assign bus.MemErr     = mem_err_q;
`endif

endmodule : pep9_mem_responder

// File: tb/tb_pep9_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_pep9_mem_responder
//
// Drives directed and randomized requests into pep9_mem_responder. A
// reference model (associative byte array plus "last read value") computes
// each transaction's expected outcome when it is issued and pushes it into
// a queue; an independent monitor pops one entry for every DoneMem pulse
// and compares read data, latency, Busy length and (optionally) MemErr.
// ---------------------------------------------------------------------------
module tb_pep9_mem_responder;

  localparam int ADDR_W      = 16;
  localparam int MEM_DEPTH   = 4096;
  localparam int WAIT_CYCLES = 2;
  localparam int TIMEOUT     = 40;

  logic        Sysclk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  pep9_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  pep9_mem_responder #(
    .ADDR_W      (ADDR_W),
    .MEM_DEPTH   (MEM_DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .Sysclk (Sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 Sysclk = ~Sysclk;

  always @(posedge Sysclk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  data;
    logic        err;
    int unsigned acc;
  } exp_t;

  logic [7:0] ref_mem [int];
  logic [7:0] ref_last_read;
  int         written [$];
  exp_t       exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic model_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                           output exp_t e);
    int idx;
    bit oob;
    idx = int'(a) % MEM_DEPTH;
    oob = 1'b0;
`ifdef MEM_BOUNDS_ERR_EN
    oob = (int'(a) >= MEM_DEPTH);
`endif
    if (!oob) begin
      if (w) begin
        ref_mem[idx] = d;
        written.push_back(idx);
      end else begin
        ref_last_read = ref_mem[idx];
      end
    end
    e.data = ref_last_read;
    e.err  = oob;
    e.acc  = 0;
  endtask

  // ---------------- driver ----------------
  // Call at a negedge with the DUT idle. scramble: 0 = bus left alone while
  // busy, 1 = address/data forced to 0x0020/0xFF, 2 = random garbage on all
  // request lines including MemReq. hold keeps MemReq high after DoneMem.
  task automatic txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                     input bit hold, input int scramble);
    exp_t e;
    int   n;
    bus.MemReq      = 1'b1;
    bus.we          = w;
    bus.address     = a;
    bus.DatatoWrite = d;
    model_txn(w, a, d, e);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge Sysclk);
      n++;
      if (bus.DoneMem !== 1'b1) begin
        if (scramble == 1) begin
          bus.address     = 16'h0020;
          bus.DatatoWrite = 8'hFF;
        end else if (scramble == 2) begin
          bus.address     = 16'($urandom);
          bus.DatatoWrite = 8'($urandom);
          bus.we          = 1'($urandom_range(0, 1));
          bus.MemReq      = 1'($urandom_range(0, 1));
        end
      end
    end while (bus.DoneMem !== 1'b1 && n < TIMEOUT);
    if (bus.DoneMem !== 1'b1) begin
      check("done_timeout", 32'd0, 32'd1);
      finish_run();
    end
    bus.MemReq = hold;
    @(negedge Sysclk);
    check("idle_busy", {31'd0, bus.Busy}, 32'd0);
    check("idle_done", {31'd0, bus.DoneMem}, 32'd0);
    check("held_rdata", {24'd0, bus.DatatoRead}, {24'd0, ref_last_read});
  endtask

  // ---------------- monitor / scoreboard ----------------
  int busy_run = 0;
  always @(negedge Sysclk) begin
    exp_t m;
    if (reset === 1'b1 || bus.Busy !== 1'b1) busy_run = 0;
    else busy_run++;
    if (bus.DoneMem === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        m = exp_q.pop_front();
        check("rdata", {24'd0, bus.DatatoRead}, {24'd0, m.data});
        check("latency", cyc - m.acc, WAIT_CYCLES + 1);
        check("busy_len", busy_run, WAIT_CYCLES + 2);
`ifdef MEM_BOUNDS_ERR_EN
        check("memerr", {31'd0, bus.MemErr}, {31'd0, m.err});
`endif
      end
    end
  end

  // Absolute time bound
  initial begin
    #500000;
    check("global_timeout", 32'd0, 32'd1);
    finish_run();
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    logic [15:0] hi;
    int          idx;
    logic        w;

    reset           = 1'b1;
    bus.MemReq      = 1'b0;
    bus.we          = 1'b0;
    bus.address     = 16'h0000;
    bus.DatatoWrite = 8'h00;
    ref_last_read   = 8'h00;
    repeat (3) @(negedge Sysclk);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.DoneMem}, 32'd0);
    check("rst_rdata", {24'd0, bus.DatatoRead}, 32'd0);
`ifdef MEM_BOUNDS_ERR_EN
    check("rst_memerr", {31'd0, bus.MemErr}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge Sysclk);

    // basic write then read
    txn(1'b1, 16'h0000, 8'h61, 1'b0, 0);
    txn(1'b0, 16'h0000, 8'h00, 1'b0, 0);

    // aliasing / out-of-range
    txn(1'b1, 16'h0005, 8'h3C, 1'b0, 0);
    txn(1'b1, 16'h1005, 8'hA5, 1'b0, 0);
    txn(1'b0, 16'h0005, 8'h00, 1'b0, 0);

    // MemReq held high, alternating 0x0010/0x0011
    for (int i = 0; i < 6; i++) begin
      txn((i < 2) ? 1'b1 : 1'b0, 16'h0010 + 16'(i % 2), 8'(8'h40 + i), (i != 5), 0);
    end

    // bus changes during WAIT are ignored
    txn(1'b1, 16'h0020, 8'h5A, 1'b0, 0);
    txn(1'b1, 16'h0030, 8'h11, 1'b0, 1);
    txn(1'b0, 16'h0030, 8'h00, 1'b0, 0);
    txn(1'b0, 16'h0020, 8'h00, 1'b0, 0);

    // reset during WAIT drops the pending write
    txn(1'b1, 16'h0040, 8'h33, 1'b0, 0);
    bus.MemReq      = 1'b1;
    bus.we          = 1'b1;
    bus.address     = 16'h0040;
    bus.DatatoWrite = 8'h77;
    @(negedge Sysclk);
    reset      = 1'b1;
    bus.MemReq = 1'b0;
    @(negedge Sysclk);
    check("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_mid_done", {31'd0, bus.DoneMem}, 32'd0);
    check("rst_mid_rdata", {24'd0, bus.DatatoRead}, 32'd0);
    reset         = 1'b0;
    ref_last_read = 8'h00;
    repeat (6) @(negedge Sysclk);
    txn(1'b0, 16'h0040, 8'h00, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      hi = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 15)) << 12 : 16'h0000;
      w  = (written.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (w) idx = $urandom_range(0, 63);
      else   idx = written[$urandom_range(0, written.size() - 1)];
      a = hi | 16'(idx);
      txn(w, a, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    bus.MemReq = 1'b0;
    repeat (8) @(negedge Sysclk);
    check("queue_empty", exp_q.size(), 32'd0);
    finish_run();
  end

endmodule : tb_pep9_mem_responder
